fwd_hazard_unit: RTL

Parametrised operand-forwarding and load-use interlock unit for the 16-bit pipelined core, sitting between the decode stage and the operand muxes of the ALU stage. It keeps an internal history of the last DEPTH issued instructions' write-back destinations and generates, per source operand, the forwarding select and a stall request. It generalises the fixed two-instruction forwarding detection (previous and two-back) in the decode unit to any history depth, register count and load latency. It adds bubble insertion, flush and a stall counter.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fwd_hazard_unit_if.sv | 39 +++
 rtl/fwd_hazard_unit_match.sv | 38 +++
 rtl/fwd_hazard_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: instruction field
// positions, register-index width derivation and the history entry format
// used by the forwarding/interlock logic.
package core_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int FIELD_W = 3;

  // Widest register index a history entry can hold; narrower indices are
  // zero-extended so the struct stays independent of NREG.
  localparam int REG_W_MAX = 8;

  function automatic int reg_idx_w(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  typedef struct packed {
    logic                 v;
    logic [REG_W_MAX-1:0] dest;
    logic                 writes;
    logic                 is_load;
  } hist_entry_t;

  localparam int HE_W = $bits(hist_entry_t);

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle of the forwarding/interlock unit. master = decode
// stage, slave = the hazard unit.
interface fwd_hazard_unit_if
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 8,
  parameter int CNT_W = 16
);

  localparam int RW = reg_idx_w(NREG);
  localparam int FW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [RW-1:0]    src_a;
  logic [RW-1:0]    src_b;
  logic             use_a;
  logic             use_b;
  logic [RW-1:0]    dest;
  logic             writes;
  logic             is_load;
  logic             flush;
  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output in_valid, src_a, src_b, use_a, use_b, dest, writes, is_load, flush,
    input  in_ready, fwd_a, fwd_b, stall, stall_count
  );

  modport slave (
    input  in_valid, src_a, src_b, use_a, use_b, dest, writes, is_load, flush,
    output in_ready, fwd_a, fwd_b, stall, stall_count
  );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Per-operand youngest-match search over the issue history. Returns the
// slot number of the youngest producer of src (0 = none) and whether that
// producer is a load.
module fwd_match
  import core_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int RW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic [RW-1:0]                src,
  input  logic                         use_s,
  input  logic [DEPTH*HE_W-1:0]        hist_flat,
  output logic [$clog2(DEPTH+1)-1:0]   match_idx,
  output logic                         match_load
);

  localparam int FW = $clog2(DEPTH + 1);

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    hist_entry_t ent;
    logic        src_zero;
    match_idx  = '0;
    match_load = 1'b0;
    ent        = '0;
    src_zero   = (ZERO_REG != 0) && (src == '0);
    for (int k = DEPTH; k >= 1; k--) begin
      ent = hist_entry_t'(hist_flat[(k-1)*HE_W +: HE_W]);
      if (ent.v && ent.writes && use_s && !src_zero &&
          ent.dest == REG_W_MAX'(src)) begin
        match_idx  = FW'(k);
        match_load = ent.is_load;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use interlock unit. Holds the write-back
// history of the last DEPTH issued instructions, selects the forwarding
// source per operand and stalls decode while a load result is too young.
module fwd_hazard_unit
  import core_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int NREG      = 8,
  parameter int LOAD_SLOT = 2,
  parameter int ZERO_REG  = 0,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  bus
);

  localparam int RW = reg_idx_w(NREG);
  localparam int FW = $clog2(DEPTH + 1);

  // Registered history: slot 1 is the most recently issued instruction.
  logic                 hist_v_p1    [1:DEPTH];
  logic [REG_W_MAX-1:0] hist_dest_p1 [1:DEPTH];
  logic                 hist_wr_p1   [1:DEPTH];
  logic                 hist_ld_p1   [1:DEPTH];

  logic [DEPTH*HE_W-1:0] hist_flat;
  logic [FW-1:0]         idx_a;
  logic [FW-1:0]         idx_b;
  logic                  ld_a;
  logic                  ld_b;
  logic                  stall_c;
  logic                  push;
  logic [CNT_W-1:0]      stall_cnt_p1;

  // A producer is too young when it is a load still in front of LOAD_SLOT.
  function automatic logic too_young(input logic [FW-1:0] idx, input logic ld);
    return ld && (idx != '0) && (int'(idx) < LOAD_SLOT);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Pack the history into the flat entry vector the matchers consume.
  always_comb begin
    hist_flat = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      hist_flat[(k-1)*HE_W +: HE_W] =
        {hist_v_p1[k], hist_dest_p1[k], hist_wr_p1[k], hist_ld_p1[k]};
    end
  end

  fwd_match #(.DEPTH(DEPTH), .RW(RW), .ZERO_REG(ZERO_REG)) u_match_a (
    .src        (bus.src_a),
    .use_s      (bus.use_a),
    .hist_flat  (hist_flat),
    .match_idx  (idx_a),
    .match_load (ld_a)
  );

  fwd_match #(.DEPTH(DEPTH), .RW(RW), .ZERO_REG(ZERO_REG)) u_match_b (
    .src        (bus.src_b),
    .use_s      (bus.use_b),
    .hist_flat  (hist_flat),
    .match_idx  (idx_b),
    .match_load (ld_b)
  );

  assign stall_c         = bus.in_valid & (too_young(idx_a, ld_a) | too_young(idx_b, ld_b));
  assign push            = bus.in_valid & ~stall_c;
  assign bus.stall       = stall_c;
  assign bus.in_ready    = push;
  assign bus.fwd_a       = bus.in_valid ? idx_a : '0;
  assign bus.fwd_b       = bus.in_valid ? idx_b : '0;
  assign bus.stall_count = stall_cnt_p1;

  // ---- issue -> history stage ----
  // Valid bits: shift in the accepted instruction or a bubble; flush empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) hist_v_p1[k] <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 1; k <= DEPTH; k++) hist_v_p1[k] <= 1'b0;
    end else begin
      hist_v_p1[1] <= push;
      for (int k = 2; k <= DEPTH; k++) hist_v_p1[k] <= hist_v_p1[k-1];
    end
  end

  // Payload shifts unconditionally; it is only meaningful where v is set.
  always_ff @(posedge clk) begin
    hist_dest_p1[1] <= REG_W_MAX'(bus.dest);
    hist_wr_p1[1]   <= bus.writes;
    hist_ld_p1[1]   <= bus.is_load;
    for (int k = 2; k <= DEPTH; k++) begin
      hist_dest_p1[k] <= hist_dest_p1[k-1];
      hist_wr_p1[k]   <= hist_wr_p1[k-1];
      hist_ld_p1[k]   <= hist_ld_p1[k-1];
    end
  end

  // Saturating count of interlock cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          stall_cnt_p1 <= '0;
    else if (stall_c) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

endmodule
